// File: rtl/wb_regbank_array.sv
// ---------------------------------------------------------------------------
// wb_regbank_array : Wishbone pipelined slave with RW control and RO status words
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_regbank_array #(
  parameter int                     NUM_RW      = 4,
  parameter int                     NUM_RO      = 2,
  parameter int                     ADR_WIDTH   = 3,
  parameter logic [NUM_RW*32-1:0]   RW_MASK     = '1,
  parameter logic [NUM_RW*32-1:0]   RESET_VALUE = '0,
  parameter bit                     PIPELINE_RD = 1'b1,
  parameter bit                     PIPELINE_WR = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   wb_cyc_i,
  input  logic                                   wb_stb_i,
  input  logic                                   wb_we_i,
  input  logic [ADR_WIDTH+1:2]                   wb_adr_i,
  input  logic [3:0]                             wb_sel_i,
  input  logic [31:0]                            wb_dat_i,
  output logic                                   wb_ack_o,
  output logic                                   wb_err_o,
  output logic                                   wb_rty_o,
  output logic                                   wb_stall_o,
  output logic [31:0]                            wb_dat_o,
  output logic [NUM_RW*32-1:0]                   regs_o,
  output logic [NUM_RW-1:0]                      wr_stb_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] sts_i,
  output logic [((NUM_RO > 0) ? NUM_RO : 1)-1:0]    rd_stb_o
);

  localparam int RO_W = (NUM_RO > 0) ? NUM_RO : 1;

  logic              wb_en, wr_req, rd_req, rd_term, ack, err;
  logic              wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
  logic              wr_v_q, wr_v_d;
  logic [ADR_WIDTH-1:0] wr_adr_q, wr_adr_d;
  logic [3:0]        wr_sel_q, wr_sel_d;
  logic [31:0]       wr_dat_q, wr_dat_d;
  logic              dec_v, wr_hit;
  logic [31:0]       dec_adr, dec_dat, bmask, wmask;
  logic [3:0]        dec_sel;
  logic [31:0]       regs_q [NUM_RW];
  logic [31:0]       regs_d [NUM_RW];
  logic              wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic [NUM_RW-1:0] wr_stb_q, wr_stb_d;
  logic [31:0]       rd_adr, rd_data, rd_dat_c;
  logic              rd_mapped, rd_ack_c, rd_err_c;
  logic [RO_W-1:0]   rd_stb_c;
  logic              rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic [31:0]       dat_q, dat_d;
  logic [RO_W-1:0]   rd_stb_q, rd_stb_d;

  always_comb begin
    wb_en     = wb_cyc_i & wb_stb_i;
    wr_req    = wb_en &  wb_we_i & ~wr_busy_q & ~rd_busy_q;
    rd_req    = wb_en & ~wb_we_i & ~wr_busy_q & ~rd_busy_q;
    rd_ack_c  = 1'b0;
    rd_err_c  = 1'b0;
    rd_data   = '0;
    rd_stb_c  = '0;
    // Read decode: RW words come from the register file, RO words from sts_i
    rd_adr    = {{(32-ADR_WIDTH){1'b0}}, wb_adr_i};
    rd_mapped = rd_adr < 32'(NUM_RW + NUM_RO);
    for (int i = 0; i < NUM_RW; i++)
      if (rd_adr == 32'(i)) rd_data = regs_q[i];
    for (int j = 0; j < NUM_RO; j++)
      if (rd_adr == 32'(NUM_RW + j)) begin
        rd_data     = sts_i[32*j +: 32];
        rd_stb_c[j] = rd_req;
      end
    rd_ack_c  = rd_req & rd_mapped;
    rd_err_c  = rd_req & ~rd_mapped;
    rd_dat_c  = rd_req ? rd_data : 32'h0;
    rd_ack_d  = rd_ack_c;
    rd_err_d  = rd_err_c;
    rd_stb_d  = rd_stb_c;
    dat_d     = rd_dat_c;
    rd_term   = PIPELINE_RD ? (rd_ack_q | rd_err_q) : (rd_ack_c | rd_err_c);
    ack       = wr_ack_q | (PIPELINE_RD ? rd_ack_q : rd_ack_c);
    err       = wr_err_q | (PIPELINE_RD ? rd_err_q : rd_err_c);
    // Flags drop at the end of the terminating cycle so the next request lands one cycle later
    wr_busy_d = (wr_busy_q | wr_req) & ~(wr_ack_q | wr_err_q);
    rd_busy_d = (rd_busy_q | rd_req) & ~rd_term;
  end

  always_comb begin
    wr_v_d   = wr_req;
    wr_adr_d = wr_req ? wb_adr_i : wr_adr_q;
    wr_sel_d = wr_req ? wb_sel_i : wr_sel_q;
    wr_dat_d = wr_req ? wb_dat_i : wr_dat_q;
    dec_v    = PIPELINE_WR ? wr_v_q : wr_req;
    dec_adr  = {{(32-ADR_WIDTH){1'b0}}, (PIPELINE_WR ? wr_adr_q : wb_adr_i)};
    dec_sel  = PIPELINE_WR ? wr_sel_q : wb_sel_i;
    dec_dat  = PIPELINE_WR ? wr_dat_q : wb_dat_i;
    wr_hit   = dec_v & (dec_adr < 32'(NUM_RW));
    wr_ack_d = wr_hit;
    wr_err_d = dec_v & ~wr_hit;
    bmask    = {{8{dec_sel[3]}}, {8{dec_sel[2]}}, {8{dec_sel[1]}}, {8{dec_sel[0]}}};
    wmask    = '0;
    wr_stb_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      regs_d[i]   = regs_q[i];
      wr_stb_d[i] = wr_hit & (dec_adr == 32'(i));
      if (wr_stb_d[i]) begin
        wmask     = bmask & RW_MASK[32*i +: 32];
        regs_d[i] = (regs_q[i] & ~wmask) | (dec_dat & wmask);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_busy_q <= 1'b0;
      rd_busy_q <= 1'b0;
      wr_v_q    <= 1'b0;
      wr_adr_q  <= '0;
      wr_sel_q  <= '0;
      wr_dat_q  <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      wr_stb_q  <= '0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_stb_q  <= '0;
      dat_q     <= '0;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= RESET_VALUE[32*i +: 32];
    end else begin
      wr_busy_q <= wr_busy_d;
      rd_busy_q <= rd_busy_d;
      wr_v_q    <= wr_v_d;
      wr_adr_q  <= wr_adr_d;
      wr_sel_q  <= wr_sel_d;
      wr_dat_q  <= wr_dat_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
      wr_stb_q  <= wr_stb_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
      rd_stb_q  <= rd_stb_d;
      dat_q     <= dat_d;
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar i = 0; i < NUM_RW; i++) begin : g_regs_o
    assign regs_o[32*i +: 32] = regs_q[i];
  end

  assign wb_ack_o   = ack;
  assign wb_err_o   = err;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = wb_en & ~(ack | err);
  assign wb_dat_o   = PIPELINE_RD ? dat_q : rd_dat_c;
  assign rd_stb_o   = PIPELINE_RD ? rd_stb_q : rd_stb_c;
  assign wr_stb_o   = wr_stb_q;

endmodule

`default_nettype wire
